// File: rtl/fetch_decode_ctrl_pkg.sv
// Shared types and constants for the fetch/decode controller.
// Holds the opcode map, FSM state encoding and writeback selects.
package fetch_decode_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_IMM = 2'd1,
        WB_MEM = 2'd2
    } wb_sel_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_CMP = 4'h8;
    localparam logic [3:0] OP_INC = 4'h9;
    localparam logic [3:0] OP_DEC = 4'hA;
    localparam logic [3:0] OP_NOT = 4'hB;
    localparam logic [3:0] OP_MVI = 4'hC;
    localparam logic [3:0] OP_LDA = 4'hD;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/fetch_decode_ctrl_if.sv
// ROM and execute-side bus of the fetch/decode controller.
// master = controller, slave = ROM/datapath side.
interface fetch_decode_ctrl_if;

    logic        rom_read;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [3:0]  alu_op;
    logic [5:0]  rd_addr;
    logic [5:0]  rs_addr;
    logic        alu_en;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        mem_read;
    logic [7:0]  mem_addr;

    modport master (
        output rom_read, rom_addr,
        input  rom_data,
        output alu_op, rd_addr, rs_addr,
        output alu_en, reg_we, wb_sel,
        output mem_read, mem_addr
    );

    modport slave (
        input  rom_read, rom_addr,
        output rom_data,
        input  alu_op, rd_addr, rs_addr,
        input  alu_en, reg_we, wb_sel,
        input  mem_read, mem_addr
    );

endinterface

// File: rtl/fetch_decode_ctrl_instr_decoder.sv
// Combinational opcode decoder: strobes and writeback select.
// Results are only meaningful while the controller is in EXEC.
module instr_decoder
    import fetch_decode_ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic       o_alu_en,
    output logic       o_reg_we,
    output logic [1:0] o_wb_sel,
    output logic       o_is_lda,
    output logic       o_illegal
);

    always_comb begin
        o_alu_en  = 1'b0;
        o_reg_we  = 1'b0;
        o_wb_sel  = WB_ALU;
        o_is_lda  = 1'b0;
        o_illegal = 1'b0;
        unique case (1'b1)
            is_alu_op(i_opcode): begin
                o_alu_en = 1'b1;
                o_reg_we = 1'b1;
            end
            (i_opcode == OP_MVI): begin
                o_reg_we = 1'b1;
                o_wb_sel = WB_IMM;
            end
            (i_opcode == OP_LDA): o_is_lda = 1'b1;
            // E and F fall through as NOP after flagging
            (i_opcode > OP_LDA): o_illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode controller: FSM, PC and instruction register.
// Fetch-latch-exec per instruction, with MEM/WB added for LDA.
module fetch_decode_ctrl
    import fetch_decode_ctrl_pkg::*;
#(
    parameter logic [7:0] PC_START = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_run,
    input  logic                   i_pc_load,
    input  logic [7:0]             i_pc_value,
    output logic [7:0]             o_pc,
    output logic                   o_busy,
    output logic                   o_illegal,
    fetch_decode_ctrl_if.master    bus
);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_pc;
    logic [15:0] r_ir;

    logic        w_dec_alu_en;
    logic        w_dec_reg_we;
    logic [1:0]  w_dec_wb_sel;
    logic        w_dec_is_lda;
    logic        w_dec_illegal;

    logic        w_rom_read;
    logic        w_alu_en;
    logic        w_reg_we;
    logic [1:0]  w_wb_sel;
    logic        w_mem_read;
    logic        w_illegal;

    instr_decoder u_dec (
        .i_opcode  (r_ir[15:12]),
        .o_alu_en  (w_dec_alu_en),
        .o_reg_we  (w_dec_reg_we),
        .o_wb_sel  (w_dec_wb_sel),
        .o_is_lda  (w_dec_is_lda),
        .o_illegal (w_dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= PC_START;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && i_pc_load)
                r_pc <= i_pc_value;
            else if (r_state == ST_EXEC)
                r_pc <= r_pc + 8'd1;
            if (r_state == ST_LATCH)
                r_ir <= bus.rom_data;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_rom_read = 1'b0;
        w_alu_en   = 1'b0;
        w_reg_we   = 1'b0;
        w_wb_sel   = WB_ALU;
        w_mem_read = 1'b0;
        w_illegal  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_run)
                    w_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_rom_read = 1'b1;
                w_next     = ST_LATCH;
            end
            ST_LATCH: w_next = ST_EXEC;
            ST_EXEC: begin
                w_alu_en  = w_dec_alu_en;
                w_reg_we  = w_dec_reg_we;
                w_wb_sel  = w_dec_wb_sel;
                w_illegal = w_dec_illegal;
                // run is only sampled at instruction boundaries
                if (w_dec_is_lda)
                    w_next = ST_MEM;
                else
                    w_next = i_run ? ST_FETCH : ST_IDLE;
            end
            ST_MEM: begin
                w_mem_read = 1'b1;
                w_next     = ST_WB;
            end
            ST_WB: begin
                w_reg_we = 1'b1;
                w_wb_sel = WB_MEM;
                w_next   = i_run ? ST_FETCH : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.rom_read = w_rom_read;
    assign bus.rom_addr = r_pc;
    assign bus.alu_op   = r_ir[15:12];
    assign bus.rd_addr  = r_ir[11:6];
    assign bus.rs_addr  = r_ir[5:0];
    assign bus.alu_en   = w_alu_en;
    assign bus.reg_we   = w_reg_we;
    assign bus.wb_sel   = w_wb_sel;
    assign bus.mem_read = w_mem_read;
    assign bus.mem_addr = {2'b00, r_ir[5:0]};

    assign o_pc      = r_pc;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_illegal = w_illegal;

endmodule
